// File: rtl/control_multiciclo.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB around a
// shared memory ready handshake and parks in TRAP on illegal encodings or memory timeouts.
module control_multiciclo #(
  parameter int SUPPORT_JUMPS = 1,
  parameter int MAX_WAIT      = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       cero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t        cur_state, nxt_state;
  logic [CW-1:0] wait_cnt;
  logic          is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal, is_jalr;
  logic          legal, timeout;

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_br   = (opcode == OP_BR);
  assign is_lui  = (opcode == OP_LUI);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);

  assign legal = is_r || is_i || is_ld || is_st || is_lui ||
                 (is_br && (funct3 == 3'b000 || funct3 == 3'b001)) ||
                 ((is_jal || is_jalr) && (SUPPORT_JUMPS != 0));

  // Timeout only ever fires while a memory request is outstanding.
  assign timeout = (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT)) && !mem_ready;

  assign state = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (nxt_state != cur_state)
      wait_cnt <= '0;
    else if ((cur_state == FETCH || cur_state == MEM) && !mem_ready && MAX_WAIT != 0)
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    nxt_state    = cur_state;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    alu_src_b    = 1'b0;
    alu_op       = 4'b0000;
    instr_done   = 1'b0;
    illegal      = 1'b0;

    case (cur_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          nxt_state = DECODE;
        end else if (timeout) begin
          nxt_state = TRAP;
        end
      end
      DECODE: nxt_state = legal ? EXEC : TRAP;
      EXEC: begin
        nxt_state = WB;
        if (is_r) begin
          alu_op = {funct7_5, funct3};
        end else if (is_i) begin
          alu_src_b = 1'b1;
          alu_op    = {funct7_5 & (funct3 == 3'b101), funct3};
        end else if (is_ld || is_st) begin
          alu_src_b = 1'b1;
          nxt_state = MEM;
        end else if (is_br) begin
          alu_op     = 4'b1000;
          pc_src     = 2'b01;
          pc_we      = funct3[0] ? !cero : cero;
          instr_done = 1'b1;
          nxt_state  = FETCH;
        end else if (is_jal) begin
          pc_we  = 1'b1;
          pc_src = 2'b01;
        end else if (is_jalr) begin
          alu_src_b = 1'b1;
          pc_we     = 1'b1;
          pc_src    = 2'b10;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = is_st;
        if (mem_ready) begin
          instr_done = is_st;
          nxt_state  = is_st ? FETCH : WB;
        end else if (timeout) begin
          nxt_state = TRAP;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        nxt_state  = FETCH;
        if (is_ld)                  wb_sel = 2'b01;
        else if (is_lui)            wb_sel = 2'b10;
        else if (is_jal || is_jalr) wb_sel = 2'b11;
      end
      TRAP: illegal = 1'b1;
      default: nxt_state = TRAP;
    endcase

    // Reset gates every output so nothing strobes while rst_n is low.
    if (!rst_n) begin
      pc_we        = 1'b0;
      pc_src       = 2'b00;
      ir_we        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'b00;
      alu_src_b    = 1'b0;
      alu_op       = 4'b0000;
      instr_done   = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: a directed table, an instruction-level reference
// model driven with random waits/opcodes, and hand-written reset/timeout sequences.
module tb_control_multiciclo;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f75;
    logic       cz;
    int         lat;
    int         aop;
    int         pcw;
    int         wbs;
    int         trp;
    string      name;
  } vec_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, cero, mem_ready;

  logic       pc_we_m, ir_we_m, mem_req_m, mem_we_m, mas_m, reg_we_m, asb_m, done_m, ill_m;
  logic [1:0] pc_src_m, wb_sel_m;
  logic [3:0] alu_op_m;
  logic [2:0] state_m;
  logic       pc_we_n, ir_we_n, mem_req_n, mem_we_n, mas_n, reg_we_n, asb_n, done_n, ill_n;
  logic [1:0] pc_src_n, wb_sel_n;
  logic [3:0] alu_op_n;
  logic [2:0] state_n;
  ctl_t       vec_m, vec_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_multiciclo #(.SUPPORT_JUMPS(1), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .cero(cero), .mem_ready(mem_ready), .pc_we(pc_we_m), .pc_src(pc_src_m),
    .ir_we(ir_we_m), .mem_req(mem_req_m), .mem_we(mem_we_m), .mem_addr_src(mas_m),
    .reg_we(reg_we_m), .wb_sel(wb_sel_m), .alu_src_b(asb_m), .alu_op(alu_op_m),
    .instr_done(done_m), .illegal(ill_m), .state(state_m)
  );

  control_multiciclo #(.SUPPORT_JUMPS(0), .MAX_WAIT(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .cero(cero), .mem_ready(mem_ready), .pc_we(pc_we_n), .pc_src(pc_src_n),
    .ir_we(ir_we_n), .mem_req(mem_req_n), .mem_we(mem_we_n), .mem_addr_src(mas_n),
    .reg_we(reg_we_n), .wb_sel(wb_sel_n), .alu_src_b(asb_n), .alu_op(alu_op_n),
    .instr_done(done_n), .illegal(ill_n), .state(state_n)
  );

  assign vec_m = {state_m, pc_we_m, pc_src_m, ir_we_m, mem_req_m, mem_we_m, mas_m,
                  reg_we_m, wb_sel_m, asb_m, alu_op_m, done_m, ill_m};
  assign vec_n = {state_n, pc_we_n, pc_src_n, ir_we_n, mem_req_n, mem_we_n, mas_n,
                  reg_we_n, wb_sel_n, asb_n, alu_op_n, done_n, ill_n};

  function automatic logic rbit();
    logic [31:0] t;
    t = $urandom();
    return t[0];
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic compareVec(input string name, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, compare against expectation, advance.
  task automatic checkCycle(input logic rdy, input ctl_t exp, input bit nj, input string name);
    mem_ready = rdy;
    #1;
    compareVec(name, nj ? vec_n : vec_m, exp);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    compareVec("reset_main", vec_m, '0);
    compareVec("reset_nojump", vec_n, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic trapTail(input bit nj);
    ctl_t e;
    e = '0;
    e.st = 3'd5;
    e.illegal = 1'b1;
    for (int i = 0; i < 3; i++) checkCycle(rbit(), e, nj, "trap_hold");
  endtask

  // Instruction-level reference: expected control vector for every cycle,
  // derived from the instruction class and the memory wait pattern.
  task automatic runInstr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                          input logic cz, input int wf, input int wm, input bit nj,
                          output bit trapped, output int cyc);
    int   lim;
    bit   rr, ia, ld, st, br, lui, jal, jalr, legal;
    logic rdy;
    ctl_t e;
    lim  = nj ? 0 : 15;
    rr   = (opc == OP_R);   ia  = (opc == OP_I);   ld   = (opc == OP_LD);
    st   = (opc == OP_ST);  br  = (opc == OP_BR);  lui  = (opc == OP_LUI);
    jal  = (opc == OP_JAL); jalr = (opc == OP_JALR);
    legal = rr || ia || ld || st || lui || (br && f3 inside {3'b000, 3'b001}) ||
            ((jal || jalr) && !nj);
    trapped = 0;
    cyc = 0;
    opcode = opc; funct3 = f3; funct7_5 = f75; cero = cz;

    for (int i = 0; i <= wf; i++) begin
      rdy = (i == wf);
      e = '0;
      e.mem_req = 1'b1;
      e.ir_we = rdy;
      e.pc_we = rdy;
      checkCycle(rdy, e, nj, "fetch");
      cyc++;
      if (!rdy && lim != 0 && i == lim) begin
        trapTail(nj); trapped = 1; return;
      end
    end

    e = '0;
    e.st = 3'd1;
    checkCycle(rbit(), e, nj, "decode");
    cyc++;
    if (!legal) begin
      trapTail(nj); trapped = 1; return;
    end

    e = '0;
    e.st = 3'd2;
    if (rr) begin
      e.alu_op = {f75, f3};
    end else if (ia) begin
      e.alu_src_b = 1'b1;
      e.alu_op = {f75 & (f3 == 3'b101), f3};
    end else if (ld || st) begin
      e.alu_src_b = 1'b1;
    end else if (br) begin
      e.alu_op = 4'b1000;
      e.pc_src = 2'b01;
      e.pc_we = f3[0] ? !cz : cz;
      e.instr_done = 1'b1;
    end else if (jal) begin
      e.pc_we = 1'b1;
      e.pc_src = 2'b01;
    end else if (jalr) begin
      e.alu_src_b = 1'b1;
      e.pc_we = 1'b1;
      e.pc_src = 2'b10;
    end
    checkCycle(rbit(), e, nj, "exec");
    cyc++;
    if (br) return;

    if (ld || st) begin
      for (int i = 0; i <= wm; i++) begin
        rdy = (i == wm);
        e = '0;
        e.st = 3'd3;
        e.mem_req = 1'b1;
        e.mem_addr_src = 1'b1;
        e.mem_we = st;
        e.instr_done = st && rdy;
        checkCycle(rdy, e, nj, "mem");
        cyc++;
        if (!rdy && lim != 0 && i == lim) begin
          trapTail(nj); trapped = 1; return;
        end
      end
      if (st) return;
    end

    e = '0;
    e.st = 3'd4;
    e.reg_we = 1'b1;
    e.instr_done = 1'b1;
    e.wb_sel = ld ? 2'b01 : lui ? 2'b10 : (jal || jalr) ? 2'b11 : 2'b00;
    checkCycle(rbit(), e, nj, "wb");
    cyc++;
  endtask

  // Zero-wait run of one table entry, observing the main DUT only.
  task automatic applyStimulus(input vec_t v, output int lat, output int aop,
                               output int pcw, output int wbs, output int trp);
    opcode = v.opc; funct3 = v.f3; funct7_5 = v.f75; cero = v.cz; mem_ready = 1'b1;
    lat = 0; aop = 0; pcw = 0; wbs = 0; trp = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (state_m == 3'd2) begin
        aop = int'(alu_op_m);
        pcw = int'(pc_we_m);
      end
      if (done_m) begin
        lat = c;
        wbs = int'(wb_sel_m);
      end
      if (ill_m) begin
        lat = c;
        trp = 1;
      end
      @(negedge clk);
      if (lat != 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl[14];
    int          lat, aop, pcw, wbs, trp, cyc, k, wf, wm;
    bit          trapped;
    logic [31:0] t;
    logic [6:0]  ops[9];
    ctl_t        e;

    tbl[0]  = '{OP_R,    3'b000, 1'b0, 1'b0, 4, 0,  0, 0, 0, "add"};
    tbl[1]  = '{OP_R,    3'b000, 1'b1, 1'b0, 4, 8,  0, 0, 0, "sub"};
    tbl[2]  = '{OP_I,    3'b101, 1'b1, 1'b0, 4, 13, 0, 0, 0, "srai"};
    tbl[3]  = '{OP_I,    3'b000, 1'b1, 1'b0, 4, 0,  0, 0, 0, "addi_f75"};
    tbl[4]  = '{OP_LD,   3'b010, 1'b0, 1'b0, 5, 0,  0, 1, 0, "lw"};
    tbl[5]  = '{OP_ST,   3'b010, 1'b0, 1'b0, 4, 0,  0, 0, 0, "sw"};
    tbl[6]  = '{OP_BR,   3'b000, 1'b0, 1'b1, 3, 8,  1, 0, 0, "beq_taken"};
    tbl[7]  = '{OP_BR,   3'b001, 1'b0, 1'b0, 3, 8,  1, 0, 0, "bne_taken"};
    tbl[8]  = '{OP_BR,   3'b001, 1'b0, 1'b1, 3, 8,  0, 0, 0, "bne_not"};
    tbl[9]  = '{OP_LUI,  3'b000, 1'b0, 1'b0, 4, 0,  0, 2, 0, "lui"};
    tbl[10] = '{OP_JAL,  3'b000, 1'b0, 1'b0, 4, 0,  1, 3, 0, "jal"};
    tbl[11] = '{OP_JALR, 3'b000, 1'b0, 1'b0, 4, 0,  1, 3, 0, "jalr"};
    tbl[12] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 3, 0, 0, 0, 1, "bad_opcode"};
    tbl[13] = '{OP_BR,   3'b100, 1'b0, 1'b0, 3, 0,  0, 0, 1, "blt_illegal"};
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_JAL, OP_JALR, 7'b1111111};

    rst_n = 1'b0; opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b0; cero = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    doReset();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i], lat, aop, pcw, wbs, trp);
      checkOutput({tbl[i].name, "_latency"}, lat, tbl[i].lat);
      checkOutput({tbl[i].name, "_alu_op"}, aop, tbl[i].aop);
      checkOutput({tbl[i].name, "_pc_we"}, pcw, tbl[i].pcw);
      checkOutput({tbl[i].name, "_wb_sel"}, wbs, tbl[i].wbs);
      checkOutput({tbl[i].name, "_trap"}, trp, tbl[i].trp);
      if (trp != 0) doReset();
    end

    $display("[TB] load with three wait cycles in MEM");
    doReset();
    runInstr(OP_LD, 3'b010, 1'b0, 1'b0, 0, 3, 0, trapped, cyc);
    checkOutput("load_wait_latency", cyc, 8);
    runInstr(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0, 0, trapped, cyc);
    checkOutput("bne_taken_latency", cyc, 3);
    runInstr(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0, 0, trapped, cyc);
    checkOutput("bne_not_latency", cyc, 3);

    $display("[TB] fetch timeout and ready on the limit cycle");
    runInstr(OP_R, 3'b000, 1'b0, 1'b0, 16, 0, 0, trapped, cyc);
    checkOutput("fetch_timeout_trap", int'(trapped), 1);
    checkOutput("fetch_timeout_cycles", cyc, 16);
    doReset();
    runInstr(OP_R, 3'b000, 1'b0, 1'b0, 15, 0, 0, trapped, cyc);
    checkOutput("fetch_ready_at_limit", int'(trapped), 0);
    runInstr(OP_ST, 3'b010, 1'b0, 1'b0, 0, 16, 0, trapped, cyc);
    checkOutput("mem_timeout_trap", int'(trapped), 1);
    doReset();

    $display("[TB] reset in the middle of a store");
    opcode = OP_ST; funct3 = 3'b010; funct7_5 = 1'b0;
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    checkCycle(1'b1, e, 0, "rst_seq_fetch");
    e = '0; e.st = 3'd1;
    checkCycle(1'b0, e, 0, "rst_seq_decode");
    e = '0; e.st = 3'd2; e.alu_src_b = 1'b1;
    checkCycle(1'b0, e, 0, "rst_seq_exec");
    mem_ready = 1'b0;
    #1;
    e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_src = 1'b1;
    compareVec("rst_seq_mem", vec_m, e);
    #2;
    rst_n = 1'b0;
    #1;
    compareVec("rst_seq_async_zero", vec_m, '0);
    @(negedge clk);
    rst_n = 1'b1;
    runInstr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 0, trapped, cyc);
    checkOutput("rst_seq_recover", cyc, 4);

    $display("[TB] jumps disabled, timeout disabled");
    doReset();
    runInstr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 1, trapped, cyc);
    checkOutput("nojump_jal_trap", int'(trapped), 1);
    doReset();
    runInstr(OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0, 1, trapped, cyc);
    checkOutput("nojump_jalr_trap", int'(trapped), 1);
    doReset();
    runInstr(OP_LD, 3'b010, 1'b0, 1'b0, 30, 25, 1, trapped, cyc);
    checkOutput("nowait_no_trap", int'(trapped), 0);
    checkOutput("nowait_latency", cyc, 60);

    $display("[TB] randomized instruction stream");
    doReset();
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 8);
      t = $urandom();
      wf = ($urandom_range(0, 11) == 0) ? 17 : $urandom_range(0, 3);
      wm = ($urandom_range(0, 11) == 0) ? 17 : $urandom_range(0, 3);
      runInstr(ops[k], t[2:0], t[3], t[4], wf, wm, 0, trapped, cyc);
      if (trapped) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multi-cycle control unit for the RV32I core. It replaces single-cycle opcode decoding with a registered FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It waits on a shared memory ready handshake, supports optional JAL/JALR, and traps on illegal encodings or memory timeouts. It sits between the instruction register and the datapath muxes, ALU, register file and the unified memory port.

## Interface
- SUPPORT_JUMPS, 1: 1 = JAL/JALR legal; 0 = those opcodes trap.
- MAX_WAIT, 15: maximum cycles without `mem_ready` before a trap. 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction register [6:0]; valid from DECODE onward.
- funct3  in  3  instruction register [14:12].
- funct7_5  in  1  instruction register [30].
- cero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_we  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch/JAL target, 10 = ALU result (JALR).
- ir_we  out  1  instruction register load enable.
- mem_req  out  1  memory request.
- mem_we  out  1  store enable, qualified by `mem_req`.
- mem_addr_src  out  1  address source: 0 = PC, 1 = ALU result.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  write-back source: 00 = ALU, 01 = memory data, 10 = immediate (LUI), 11 = link (old PC+4).
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- alu_op  out  4  ALU operation code.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  high while in TRAP.
- state  out  3  FSM state, for debug.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are combinational from the state plus the current inputs. Every output not listed for a state is 0.
- FETCH:
  - Drive `mem_req` = 1, `mem_addr_src` = 0.
  - On `mem_ready`: `ir_we` = 1, `pc_we` = 1, `pc_src` = 00, go to DECODE.
- DECODE:
  - Illegal encoding goes to TRAP; anything else goes to EXEC.
  - Illegal means any of: opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, 1100111}; branch with `funct3` not 000 or 001; JAL/JALR when SUPPORT_JUMPS = 0.
- EXEC, by opcode:
  - R-type: `alu_src_b` = 0, `alu_op` = {funct7_5, funct3}, go to WB.
  - I-ALU: `alu_src_b` = 1, `alu_op` = {funct7_5 & (funct3 == 101), funct3}, go to WB.
  - Load/store: `alu_src_b` = 1, `alu_op` = 0000, go to MEM.
  - Branch: `alu_op` = 1000 (sub), `pc_src` = 01, `pc_we` = (`funct3[0]` ? !cero : cero), `instr_done` = 1, go to FETCH.
  - LUI: go to WB.
  - JAL: `pc_we` = 1, `pc_src` = 01, go to WB.
  - JALR: `alu_src_b` = 1, `alu_op` = 0000, `pc_we` = 1, `pc_src` = 10, go to WB.
- MEM:
  - Drive `mem_req` = 1, `mem_addr_src` = 1, `mem_we` = store.
  - On `mem_ready`: a store sets `instr_done` = 1 and goes to FETCH; a load goes to WB.
- WB:
  - `reg_we` = 1, `instr_done` = 1, go to FETCH.
  - `wb_sel`: 00 for R-type/I-ALU, 01 for load, 10 for LUI, 11 for JAL/JALR.
- TRAP: `illegal` = 1, all strobes 0. Only reset leaves TRAP.
- Wait counter, width clog2(MAX_WAIT+1):
  - Clears on every state change; increments each FETCH/MEM cycle without `mem_ready`.
  - When it equals MAX_WAIT (MAX_WAIT ≠ 0) and `mem_ready` = 0, go to TRAP next cycle.
  - `mem_ready` in the same cycle as the limit wins.

## Timing
- While `rst_n` = 0:
  - `state` = FETCH and the counter = 0.
  - All outputs are forced to 0, including `mem_req`.
  - `state` reads 0.
- The first `mem_req` is asserted in the first cycle with `rst_n` high.
- An asynchronous reset mid-instruction aborts the instruction; no strobe glitches high.
- Minimum latency with zero-wait memory, in cycles:
  - Branch: 3.
  - R-type, I-ALU, LUI, JAL, JALR, store: 4.
  - Load: 5.
- Each cycle that `mem_ready` is low extends FETCH or MEM by one cycle.
- `mem_req` stays high and stable until `mem_ready` is seen; it drops in the cycle after `mem_ready`.
- Input stability:
  - `opcode`, `funct3` and `funct7_5` are sampled from DECODE through the final state.
  - `cero` is used only in the branch EXEC cycle.

## Test plan
- Zero-wait ADD (0110011, funct3 000, funct7_5 0): states 0→1→2→4→0.
  - `alu_op` = 0000 in EXEC, `reg_we` = 1 and `wb_sel` = 00 in WB.
  - `instr_done` on cycle 4.
- Load with `mem_ready` held low 3 cycles in MEM: MEM lasts 4 cycles with `mem_addr_src` = 1 and `mem_we` = 0, then WB with `wb_sel` = 01.
  - Total latency 8 cycles.
- BNE (funct3 001):
  - With `cero` = 0: `pc_we` = 1, `pc_src` = 01 in EXEC.
  - With `cero` = 1: `pc_we` = 0.
  - Either way, back in FETCH on cycle 4.
- Opcode 1111111, and JAL with SUPPORT_JUMPS = 0: TRAP after DECODE, `illegal` = 1 held; `rst_n` pulse returns to FETCH.
- MAX_WAIT = 15 with `mem_ready` stuck low in FETCH: TRAP entered after exactly 16 FETCH cycles.
  - Same stimulus but `mem_ready` rising on the 16th cycle: DECODE, no trap.
- `rst_n` asserted mid-MEM of a store: `mem_we` and `mem_req` drop to 0 immediately (asynchronous); FETCH after release.
